// File: rtl/mem_dcache.sv
// ============================================================================
// mem_dcache
// ----------------------------------------------------------------------------
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage
// of the MIPS pipeline. Loads that hit return data combinationally. Load misses
// fill a 4-word line from main memory. Every store is written through to
// memory, and the cached copy is updated only when the store hits. While a
// memory handshake is in progress, `stall` freezes the upstream pipeline.
//
// Parameters
//   INDEX_BITS  number of index bits; the cache holds 2**INDEX_BITS lines of
//               4 x 32-bit words
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   rd_en      in   load request from EX/MEM
//   wr_en      in   store request from EX/MEM (wins over rd_en)
//   addr       in   32-bit byte address; bits [1:0] are ignored
//   wdata      in   store data
//   rdata      out  load data, combinational; 0 unless a load hits in IDLE
//   stall      out  freezes PC, IF/ID, ID/EX and EX/MEM
//   mem_req    out  main-memory request (registered)
//   mem_we     out  1 = write, 0 = read (registered)
//   mem_addr   out  word-aligned memory address (registered)
//   mem_wdata  out  memory write data (registered)
//   mem_rdata  in   memory read data, valid while mem_ack = 1
//   mem_ack    in   one-cycle completion pulse for the current word
//
// Optional feature (macro DCACHE_STATS_EN)
//   hit_cnt    out  32-bit count of load hits, wraps modulo 2**32
//   miss_cnt   out  32-bit count of load misses, wraps modulo 2**32
// ============================================================================
module mem_dcache #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        WDONE
    } state_t;

    state_t state;

    // Storage: data is flattened as {index, word offset}
    logic [31:0]          data_mem [LINES*4];
    logic [TAG_BITS-1:0]  tag_mem  [LINES];
    logic [LINES-1:0]     valid;

    // Address fields of the current request
    logic [1:0]            a_off;
    logic [INDEX_BITS-1:0] a_idx;
    logic [TAG_BITS-1:0]   a_tag;
    logic                  hit;

    // Line being filled, latched when the miss is taken
    logic [TAG_BITS-1:0]   f_tag;
    logic [INDEX_BITS-1:0] f_idx;
    logic [1:0]            cnt;

    logic unused_addr_bits;

    assign a_off = addr[3:2];
    assign a_idx = addr[3+INDEX_BITS:4];
    assign a_tag = addr[31:4+INDEX_BITS];
    assign hit   = valid[a_idx] && (tag_mem[a_idx] == a_tag);

    // Byte-offset bits carry no information for a word cache.
    assign unused_addr_bits = ^addr[1:0];

    // ------------------------------------------------------------------------
    // Combinational outputs: stall and load data
    // ------------------------------------------------------------------------
    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stall = 1'b0;
        rdata = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        stall = 1'b1;
                    end else if (rd_en) begin
                        if (hit) begin
                            rdata = data_mem[{a_idx, a_off}];
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                FILL, WRITE: stall = 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and registered memory interface
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of its inputs regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            f_tag     <= '0;
            f_idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        // Write-through: every store goes to memory.
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= wdata;
                        mem_we    <= 1'b1;
                        mem_req   <= 1'b1;
                        state     <= WRITE;
                    end else if (rd_en && !hit) begin
                        f_tag    <= a_tag;
                        f_idx    <= a_idx;
                        cnt      <= 2'd0;
                        mem_we   <= 1'b0;
                        mem_req  <= 1'b1;
                        mem_addr <= {a_tag, a_idx, 2'b00, 2'b00};
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt      <= cnt + 2'd1;
                        mem_addr <= {f_tag, f_idx, cnt + 2'd1, 2'b00};
                        if (cnt == 2'd3) begin
                            // Line is marked valid only once all 4 words landed.
                            valid[f_idx] <= 1'b1;
                            mem_req      <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= WDONE;
                    end
                end
                WDONE: begin
                    // The store is still presented this cycle; do not reissue.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Data and tag arrays
    // ------------------------------------------------------------------------
    // NOTE: the arrays are deliberately not reset; contents are qualified by
    // the valid bits, which are reset, and this keeps them mappable to RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL && mem_ack) begin
                data_mem[{f_idx, cnt}] <= mem_rdata;
                if (cnt == 2'd3) begin
                    tag_mem[f_idx] <= f_tag;
                end
            end else if (state == IDLE && wr_en && hit) begin
                data_mem[{a_idx, a_off}] <= wdata;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // ------------------------------------------------------------------------
    // Hit/miss statistics. A load is counted once, when first evaluated in
    // IDLE; the hit seen in the cycle right after a fill completes belongs to
    // a load already counted as a miss, so fill_done masks it.
    // ------------------------------------------------------------------------
    logic fill_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_done <= 1'b0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            fill_done <= (state == FILL) && mem_ack && (cnt == 2'd3);
            if (state == IDLE && rd_en && !wr_en && !fill_done) begin
                if (hit) begin
                    hit_cnt <= hit_cnt + 32'd1;
                end else begin
                    miss_cnt <= miss_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_dcache.sv
// ============================================================================
// tb_mem_dcache
// ----------------------------------------------------------------------------
// Self-checking bench for mem_dcache. A behavioural main memory with a
// programmable per-word ack latency (k_lat) answers requests; it owns the
// reference memory image, so expected load data always reflect earlier
// write-through stores. Expected results per access are queued when the
// access is driven and compared when the pipeline is released.
// ============================================================================
module tb_mem_dcache;

    logic        clk;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    int          exp_hits;
    int          exp_misses;
`endif

    int checks;
    int errors;

    // Memory model state
    logic [31:0] mem [4096];
    int          k_lat;
    int          rd_acks;
    int          wr_acks;
    logic [31:0] rd_addr_q [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    typedef struct {
        logic [31:0] data;
        int          stalls;
        int          reads;
        int          writes;
    } exp_t;

    exp_t exp_q [$];

    mem_dcache dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Main memory model: acks each word k_lat cycles after it is requested.
    // Changes outputs on the falling edge so the DUT samples them cleanly.
    // ------------------------------------------------------------------------
    initial begin
        int wait_cnt;
        for (int i = 0; i < 4096; i++) mem[i] = 32'hA000_0000 | i;
        mem[32'h40 >> 2] = 32'h11;
        mem[32'h44 >> 2] = 32'h22;
        mem[32'h48 >> 2] = 32'h33;
        mem[32'h4C >> 2] = 32'h44;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rd_acks   = 0;
        wr_acks   = 0;
        wait_cnt  = 0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (wait_cnt + 1 >= k_lat) begin
                    wait_cnt = 0;
                    mem_ack  = 1'b1;
                    if (mem_we) begin
                        mem[mem_addr[13:2]] = mem_wdata;
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                        wr_acks++;
                    end else begin
                        mem_rdata = mem[mem_addr[13:2]];
                        rd_addr_q.push_back(mem_addr);
                        rd_acks++;
                    end
                end else begin
                    wait_cnt++;
                    mem_ack = 1'b0;
                end
            end else begin
                wait_cnt = 0;
                mem_ack  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pipeline access: hold the request until stall drops, then compare.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic exp_hit);
        exp_t        e;
        int          r0;
        int          w0;
        int          stalls;
        logic        timed_out;
        logic [31:0] obs;
        e.writes = wr ? 1 : 0;
        e.reads  = (!wr && !exp_hit) ? 4 : 0;
        e.stalls = wr ? 1 + k_lat : (exp_hit ? 0 : 1 + 4 * k_lat);
        e.data   = wr ? 32'h0 : mem[a[13:2]];
`ifdef DCACHE_STATS_EN
        if (!wr) begin
            if (exp_hit) exp_hits++;
            else         exp_misses++;
        end
`endif
        exp_q.push_back(e);
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();

        @(posedge clk); #1;
        rd_en = rd;
        wr_en = wr;
        addr  = a;
        wdata = d;
        r0    = rd_acks;
        w0    = wr_acks;

        stalls    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (stall) begin
                stalls++;
            end else begin
                timed_out = 1'b0;
                break;
            end
        end
        check("stall_timeout", {31'b0, timed_out}, 32'h0);

        e = exp_q.pop_front();
        check("rdata",  rdata,        e.data);
        check("stalls", stalls,       e.stalls);
        check("reads",  rd_acks - r0, e.reads);
        check("writes", wr_acks - w0, e.writes);
        for (int i = 0; i < e.reads; i++) begin
            obs = (rd_addr_q.size() > 0) ? rd_addr_q.pop_front() : 32'hxxxx_xxxx;
            check("fill_addr", obs, {a[31:4], 4'h0} + 32'(4 * i));
        end
        if (wr) begin
            obs = (wr_addr_q.size() > 0) ? wr_addr_q.pop_front() : 32'hxxxx_xxxx;
            check("wr_addr", obs, {a[31:2], 2'b00});
            obs = (wr_data_q.size() > 0) ? wr_data_q.pop_front() : 32'hxxxx_xxxx;
            check("wr_data", obs, d);
        end

        @(posedge clk); #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
`ifdef DCACHE_STATS_EN
        check("hit_cnt",  hit_cnt,  exp_hits);
        check("miss_cnt", miss_cnt, exp_misses);
`endif
    endtask

    initial begin
        int r0;
        checks = 0;
        errors = 0;
        k_lat  = 1;
`ifdef DCACHE_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
`endif

        // Reset with a pending miss presented: outputs must stay quiet.
        rst   = 1'b1;
        rd_en = 1'b1;
        wr_en = 1'b0;
        addr  = 32'h40;
        wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall",     stall,     32'h0);
        check("rst_rdata",     rdata,     32'h0);
        check("rst_mem_req",   mem_req,   32'h0);
        check("rst_mem_we",    mem_we,    32'h0);
        check("rst_mem_addr",  mem_addr,  32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt",  hit_cnt,  32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif
        rd_en = 1'b0;
        rst   = 1'b0;

        // Directed sequence, k = 1
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);           // miss + fill
        access(1'b1, 1'b0, 32'h0000_0048, 32'h0, 1'b1);           // hit 0x33
        access(1'b0, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF, 1'b0);   // store hit
        access(1'b1, 1'b0, 32'h0000_0044, 32'h0, 1'b1);           // updated word
        access(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 1'b0);   // store miss
        access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0);           // no-write-allocate
        access(1'b1, 1'b0, 32'h0000_1040, 32'h0, 1'b0);           // evicts index 4
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);           // misses again

        // Slower memory, k = 3
        k_lat = 3;
        access(1'b1, 1'b0, 32'h0000_2008, 32'h0, 1'b0);           // miss
        access(1'b1, 1'b1, 32'h0000_2008, 32'hCAFE_F00D, 1'b0);   // store wins
        access(1'b1, 1'b0, 32'h0000_2008, 32'h0, 1'b1);           // hit new data
        access(1'b0, 1'b1, 32'h0000_200C, 32'h0BAD_F00D, 1'b0);   // store, k = 3
        k_lat = 1;

        // Reset in the middle of a fill, after the 2nd ack.
        @(posedge clk); #1;
        rd_en = 1'b1;
        addr  = 32'h0000_0080;
        r0    = rd_acks;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (rd_acks - r0 >= 2) break;
        end
        check("acks_before_rst", rd_acks - r0, 32'd2);
        check("req_before_rst",  mem_req,      32'h1);
        rst = 1'b1;
        #1;
        check("req_async_drop",  mem_req,      32'h0);
        check("stall_in_rst",    stall,        32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef DCACHE_STATS_EN
        exp_hits   = 0;
        exp_misses = 0;
        check("post_rst_hit_cnt",  hit_cnt,  32'h0);
        check("post_rst_miss_cnt", miss_cnt, 32'h0);
`endif
        access(1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b0);           // fresh 4 reads
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0);           // all lines invalid

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_dcache.md
# mem_dcache

Direct-mapped, write-through, no-write-allocate data cache for the MEM stage of the MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register, which supplies the ALU result as the address, the store data, and the load/store controls. It returns load data combinationally so the MEM/WB register can capture it. A multi-cycle main-memory handshake services misses and stores, and the block raises `stall` to freeze the pipeline while that handshake is in progress.

## Interface
- `INDEX_BITS`, 8, number of index bits; the cache holds 2^INDEX_BITS lines of 4 words each.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  load request from EX/MEM.
- `wr_en`  in  1  store request from EX/MEM.
- `addr`  in  32  byte address from the EX/MEM result; bits [1:0] are ignored.
- `wdata`  in  32  store data from the EX/MEM store-data field.
- `rdata`  out  32  load data, combinational.
- `stall`  out  1  freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `mem_req`  out  1  main-memory request, registered.
- `mem_we`  out  1  1 = write, 0 = read; registered.
- `mem_addr`  out  32  word-aligned memory address; registered.
- `mem_wdata`  out  32  memory write data; registered.
- `mem_rdata`  in  32  memory read data; valid when `mem_ack` = 1.
- `mem_ack`  in  1  one-cycle completion pulse for the current word.

## Operation
- Address fields:
  - offset = `addr`[3:2]
  - index = `addr`[3+INDEX_BITS:4]
  - tag = `addr`[31:4+INDEX_BITS]
- Arrays: data (2^INDEX_BITS x 4 x 32 bits), tag, and one valid bit per line.
- Hit: the line is valid and the stored tag equals the address tag.
- FSM states:
  - **IDLE**
    - `rd_en` & hit: `rdata` = the cached word; `stall` = 0.
    - `rd_en` & miss: `stall` = 1 combinationally. Latch tag and index, set the word counter to 0, and go to FILL.
    - `wr_en`: `stall` = 1. On a hit, update the cached word at this edge; on a miss, leave the cache unchanged. Latch `addr` and `wdata` into `mem_addr` and `mem_wdata`, set `mem_we` = 1, and go to WRITE.
    - `rd_en` and `wr_en` both high: `wr_en` wins and the read is ignored.
  - **FILL**
    - Drive `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, cnt, 2'b00}, with `stall` = 1.
    - On each `mem_ack`, write `mem_rdata` into word `cnt`, then increment `cnt`; `mem_addr` advances on the next cycle.
    - On the 4th ack: set valid, write the tag, drop `mem_req`, and go to IDLE. The access then hits, so the load completes.
  - **WRITE**
    - Hold `mem_req` = 1 and `stall` = 1 until `mem_ack`.
    - On the ack edge, drop `mem_req` and `mem_we`, and go to WDONE.
  - **WDONE**
    - `stall` = 0 for one cycle, so the pipeline retires the store.
    - Request inputs are ignored, to avoid re-issuing the still-presented store; return to IDLE.
- `mem_ack` while `mem_req` = 0 is ignored.
- When there is no `rd_en` hit, `rdata` = 0.

## Timing
- Reset values: state IDLE, every valid bit 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, counter 0. `stall` and `rdata` are 0 during reset.
- Load hit: zero-cycle latency; `rdata` is valid in the cycle `rd_en` is presented.
- Load miss (ack k cycles after each request word, k ≥ 1):
  - cycle 0: `stall` rises.
  - cycle 1: `mem_req` rises.
  - Each word then takes k cycles.
  - `stall` falls in the cycle after the 4th ack, and `rdata` is valid in that same cycle.
  - With k = 1: the load completes 5 cycles after cycle 0, i.e. 5 stall cycles.
- Store: `stall` is high from cycle 0 through the ack cycle. With k = 1, that is 2 stall cycles; WDONE follows with `stall` = 0.
- `rst` mid-FILL or mid-WRITE: `mem_req` drops immediately (asynchronously) and all lines are invalidated. A partially filled line is never marked valid.
- Index wrap-around: lines that alias the same index evict each other. There is no dirty state, so eviction is silent.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_cnt` and `miss_cnt`, each 32-bit and reset to 0.
  - Each load is counted exactly once, at its IDLE evaluation. The hit that follows a completed fill is not counted.
  - Stores are not counted.
  - Both counters wrap modulo 2^32.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then `rd_en` with `addr` = 0x0000_0040 and memory returning 0x11, 0x22, 0x33, 0x44 (k = 1):
  - 4 read requests go to 0x40, 0x44, 0x48, 0x4C.
  - `stall` is high for 5 cycles, then `rdata` = 0x11.
- Immediately follow with a load from 0x0000_0048: hit, `rdata` = 0x33, `stall` = 0, no `mem_req`.
- Store 0xDEAD_BEEF to 0x0000_0044 (hit):
  - One memory write at 0x44; `stall` is high for 2 cycles, then WDONE.
  - A following load from 0x44 returns 0xDEAD_BEEF with no miss.
- Store to 0x0000_1000 (miss):
  - One memory write occurs.
  - A following load from 0x1000 misses and fills, confirming no-write-allocate.
- Load from 0x0000_1040, which aliases index 4 with 0x40:
  - It evicts that line.
  - A subsequent load from 0x40 misses again.
- Assert `rst` after the 2nd fill ack:
  - `mem_req` drops at once.
  - The next load from the same address misses and issues 4 fresh reads.
  - With `DCACHE_STATS_EN` defined: `hit_cnt` and `miss_cnt` read 0 after the reset.
